key_debounce: RTL and testbench
===============================

// Module: key_debounce
// PURPOSE
//  Input-side companion to the LED drivers. Samples one raw, asynchronous, bouncing push-button
//  pin on clk50m, synchronises and debounces it, and emits a clean level plus one-cycle
//  press/release/long-press event pulses. Sits between a board key pin and control logic
//  (e.g. LED blink-rate or mode select).
// PARAMETERS
//  DEBOUNCE_CYCLES    1000000   stable cycles required to accept a press or release (20 ms @50 MHz); >=2
//  LONG_PRESS_CYCLES  50000000  cycles in PRESSED before long_press_pulse (1 s @50 MHz); >=2
//  ACTIVE_LOW         1         1: key_in low = pressed (board keys); 0: high = pressed
// PORTS
//  clk50m           in   1  50 MHz system clock
//  reset_n          in   1  asynchronous, active-low reset
//  key_in           in   1  raw pin, asynchronous to clk50m, may bounce
//  key_level        out  1  debounced state, 1 = pressed
//  press_pulse      out  1  one-cycle pulse on accepted press
//  release_pulse    out  1  one-cycle pulse on accepted release
//  long_press_pulse out  1  one-cycle pulse when hold reaches LONG_PRESS_CYCLES
//  hold_active      out  1  1 from long_press_pulse until release accepted
// BEHAVIOUR
//  - Reset: all outputs 0; 2-FF synchroniser flops reset to the INACTIVE pin level; FSM IDLE;
//    all counters 0. Reset mid-press drops key_level with no release_pulse.
//  - act = synchroniser output, polarity-corrected by ACTIVE_LOW (1 = pressed).
//  - Debounce counter dcnt: width $clog2(DEBOUNCE_CYCLES). Long counter lcnt: width
//    $clog2(LONG_PRESS_CYCLES). Both are down-counters that never wrap below 0.
//  - All outputs are registered. Pulses are exactly 1 cycle wide.
//  - FSM states and transitions (evaluated each edge):
//    IDLE:       act=1 -> PRESS_WAIT, dcnt<=DEBOUNCE_CYCLES-1.
//    PRESS_WAIT: act=0 -> IDLE (bounce, no output). Else if dcnt==0 -> PRESSED,
//                press_pulse<=1, key_level<=1, lcnt<=LONG_PRESS_CYCLES-1. Else dcnt--.
//    PRESSED:    act=0 -> RELEASE_WAIT, dcnt<=DEBOUNCE_CYCLES-1, lcnt frozen.
//                Else if lcnt==0 -> LONG_HELD, long_press_pulse<=1, hold_active<=1. Else lcnt--.
//    LONG_HELD:  act=0 -> RELEASE_WAIT, dcnt<=DEBOUNCE_CYCLES-1. No further long pulses.
//    RELEASE_WAIT: act=1 -> return to the origin state (PRESSED or LONG_HELD, held in a
//                1-bit flag). lcnt resumes from its frozen value; no pulse is emitted.
//                Else if dcnt==0 -> IDLE, release_pulse<=1, key_level<=0, hold_active<=0.
//                Else dcnt--.
//  - Latency: the pin goes and stays active before edge k -> press_pulse is high in the cycle
//    after edge k+DEBOUNCE_CYCLES+2 (2 synchroniser edges + IDLE exit + DEBOUNCE_CYCLES).
//    The release path is symmetric.
//  - long_press_pulse asserts LONG_PRESS_CYCLES cycles after press_pulse, plus any cycles
//    spent in aborted RELEASE_WAIT excursions.
//  - Simultaneous events: act change at the same edge where dcnt==0 -> the act check wins
//    (abort). In PRESSED, act=0 at the same edge where lcnt==0 -> RELEASE_WAIT, and the long
//    pulse is deferred until the return.
//  - key_level never toggles without the matching press_pulse/release_pulse in the same cycle.
// TESTING (bench params: DEBOUNCE_CYCLES=8, LONG_PRESS_CYCLES=32, ACTIVE_LOW=1)
//  1 Clean press: key_in 1->0 before edge k, held -> press_pulse=1 only in cycle after edge
//    k+10; key_level=1 from the same cycle.
//  2 Bounce: key_in low 5 cycles, high 3, low 4, then high -> no pulses, key_level stays 0.
//    Then key_in held low -> press 10 cycles after the last transition.
//  3 Long press: hold key_in low 60 cycles -> press_pulse, then long_press_pulse exactly
//    32 cycles later with hold_active=1. Release -> release_pulse 10 cycles after the
//    pin goes high; hold_active=0 and key_level=0 in that same cycle.
//  4 Release glitch: during PRESSED with lcnt=20, pulse key_in high 4 cycles -> no release;
//    long_press_pulse delayed by 5 cycles (RELEASE_WAIT entry + 4).
//  5 Reset mid-operation: assert reset_n=0 in LONG_HELD -> all outputs 0 immediately, no
//    release_pulse. Deassert with key_in held low -> fresh press_pulse after 10 cycles.
//  6 ACTIVE_LOW=0: repeat scenario 1 with inverted key_in -> identical pulse timing.

Source files
------------

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-FF synchroniser, debounce FSM, and one-cycle
// press / release / long-press event pulses with a debounced key level.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
  parameter int unsigned LONG_PRESS_CYCLES = 50000000,
  parameter bit          ACTIVE_LOW        = 1'b1
) (
  input  logic clk50m,
  input  logic reset_n,
  input  logic key_in,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press_pulse,
  output logic hold_active
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned LW = $clog2(LONG_PRESS_CYCLES);

  localparam logic [DW-1:0] DCNT_LOAD = DW'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [DW-1:0] DCNT_ONE  = DW'(32'd1);
  localparam logic [DW-1:0] DCNT_ZERO = DW'(32'd0);
  localparam logic [LW-1:0] LCNT_LOAD = LW'(LONG_PRESS_CYCLES - 32'd1);
  localparam logic [LW-1:0] LCNT_ONE  = LW'(32'd1);
  localparam logic [LW-1:0] LCNT_ZERO = LW'(32'd0);

  // Level the pin rests at when the key is not pressed.
  localparam logic PIN_IDLE = ACTIVE_LOW;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_PRESS_WAIT   = 3'd1,
    ST_PRESSED      = 3'd2,
    ST_LONG_HELD    = 3'd3,
    ST_RELEASE_WAIT = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic          from_long_q, from_long_d;
  logic          key_level_q, key_level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;
  logic          hold_q, hold_d;
  logic          act;

  assign act = sync2_q ^ ACTIVE_LOW;

  // Next-state and output decode for the synchroniser and debounce FSM.
  always_comb begin
    sync1_d     = key_in;
    sync2_d     = sync1_q;
    state_d     = state_q;
    dcnt_d      = dcnt_q;
    lcnt_d      = lcnt_q;
    from_long_d = from_long_q;
    key_level_d = key_level_q;
    hold_d      = hold_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (act) begin
          state_d = ST_PRESS_WAIT;
          dcnt_d  = DCNT_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_PRESS_WAIT: begin
        if (!act) begin
          state_d = ST_IDLE;
        end else if (dcnt_q == DCNT_ZERO) begin
          state_d     = ST_PRESSED;
          press_d     = 1'b1;
          key_level_d = 1'b1;
          lcnt_d      = LCNT_LOAD;
        end else begin
          dcnt_d = dcnt_q - DCNT_ONE;
        end
      end

      // A release seen on the same edge as lcnt==0 wins; the long pulse
      // is then deferred until the glitch returns us here.
      ST_PRESSED: begin
        if (!act) begin
          state_d     = ST_RELEASE_WAIT;
          dcnt_d      = DCNT_LOAD;
          from_long_d = 1'b0;
        end else if (lcnt_q == LCNT_ZERO) begin
          state_d = ST_LONG_HELD;
          long_d  = 1'b1;
          hold_d  = 1'b1;
        end else begin
          lcnt_d = lcnt_q - LCNT_ONE;
        end
      end

      ST_LONG_HELD: begin
        if (!act) begin
          state_d     = ST_RELEASE_WAIT;
          dcnt_d      = DCNT_LOAD;
          from_long_d = 1'b1;
        end else begin
          state_d = ST_LONG_HELD;
        end
      end

      ST_RELEASE_WAIT: begin
        if (act) begin
          state_d = from_long_q ? ST_LONG_HELD : ST_PRESSED;
        end else if (dcnt_q == DCNT_ZERO) begin
          state_d     = ST_IDLE;
          release_d   = 1'b1;
          key_level_d = 1'b0;
          hold_d      = 1'b0;
        end else begin
          dcnt_d = dcnt_q - DCNT_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; synchroniser resets to the released pin level.
  always_ff @(posedge clk50m or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= PIN_IDLE;
      sync2_q     <= PIN_IDLE;
      state_q     <= ST_IDLE;
      dcnt_q      <= DCNT_ZERO;
      lcnt_q      <= LCNT_ZERO;
      from_long_q <= 1'b0;
      key_level_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      hold_q      <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      lcnt_q      <= lcnt_d;
      from_long_q <= from_long_d;
      key_level_q <= key_level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      hold_q      <= hold_d;
    end
  end

  assign key_level        = key_level_q;
  assign press_pulse      = press_q;
  assign release_pulse    = release_q;
  assign long_press_pulse = long_q;
  assign hold_active      = hold_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce: active-low and active-high instances with
// short debounce/long-press counts; outputs sampled 1 ns after each rising edge.
module tb_key_debounce;

  logic clk50m  = 1'b0;
  logic reset_n = 1'b0;
  logic key_a   = 1'b1;
  logic key_b   = 1'b0;

  logic lvl_a, prs_a, rel_a, lng_a, hld_a;
  logic lvl_b, prs_b, rel_b, lng_b, hld_b;
  logic [4:0] outs_a, outs_b;

  int tests = 0;
  int fails = 0;

  // Output vectors are {key_level, press, release, long_press, hold_active}.
  localparam logic [4:0] O_IDLE  = 5'b00000;
  localparam logic [4:0] O_HELD  = 5'b10000;
  localparam logic [4:0] O_PRESS = 5'b11000;
  localparam logic [4:0] O_REL   = 5'b00100;
  localparam logic [4:0] O_LONG  = 5'b10011;
  localparam logic [4:0] O_HOLD  = 5'b10001;

  key_debounce #(
    .DEBOUNCE_CYCLES  (8),
    .LONG_PRESS_CYCLES(32),
    .ACTIVE_LOW       (1'b1)
  ) dut_a (
    .clk50m          (clk50m),
    .reset_n         (reset_n),
    .key_in          (key_a),
    .key_level       (lvl_a),
    .press_pulse     (prs_a),
    .release_pulse   (rel_a),
    .long_press_pulse(lng_a),
    .hold_active     (hld_a)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES  (8),
    .LONG_PRESS_CYCLES(32),
    .ACTIVE_LOW       (1'b0)
  ) dut_b (
    .clk50m          (clk50m),
    .reset_n         (reset_n),
    .key_in          (key_b),
    .key_level       (lvl_b),
    .press_pulse     (prs_b),
    .release_pulse   (rel_b),
    .long_press_pulse(lng_b),
    .hold_active     (hld_b)
  );

  assign outs_a = {lvl_a, prs_a, rel_a, lng_a, hld_a};
  assign outs_b = {lvl_b, prs_b, rel_b, lng_b, hld_b};

  always #5 clk50m = ~clk50m;

  function automatic logic [4:0] outs(input int inst);
    return (inst == 0) ? outs_a : outs_b;
  endfunction

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
      $error("%s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk50m);
    #1;
  endtask

  task automatic step(input string tag, input int inst, input logic [4:0] exp);
    tick();
    chk(tag, outs(inst), exp);
  endtask

  task automatic quiet(input string tag, input int inst, input int n, input logic [4:0] exp);
    for (int i = 0; i < n; i++) begin
      tick();
      chk(tag, outs(inst), exp);
    end
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_a", outs_a, O_IDLE);
    chk("rst_b", outs_b, O_IDLE);
    repeat (3) tick();
    reset_n = 1'b1;
    quiet("idle", 0, 3, O_IDLE);

    // 1: clean press, press pulse in cycle after edge k+10, then release
    key_a = 1'b0;
    quiet("s1_wait", 0, 10, O_IDLE);
    step("s1_press", 0, O_PRESS);
    step("s1_hold", 0, O_HELD);
    key_a = 1'b1;
    quiet("s1_rwait", 0, 10, O_HELD);
    step("s1_rel", 0, O_REL);
    quiet("s1_idle", 0, 3, O_IDLE);
    chk("s1_b_idle", outs_b, O_IDLE);

    // 2: bounce 5 low / 3 high / 4 low / 3 high, then a held press
    key_a = 1'b0;
    quiet("s2_b1", 0, 5, O_IDLE);
    key_a = 1'b1;
    quiet("s2_b2", 0, 3, O_IDLE);
    key_a = 1'b0;
    quiet("s2_b3", 0, 4, O_IDLE);
    key_a = 1'b1;
    quiet("s2_b4", 0, 3, O_IDLE);
    key_a = 1'b0;
    quiet("s2_wait", 0, 10, O_IDLE);
    step("s2_press", 0, O_PRESS);
    key_a = 1'b1;
    quiet("s2_rwait", 0, 10, O_HELD);
    step("s2_rel", 0, O_REL);
    quiet("s2_idle", 0, 3, O_IDLE);

    // 3: long press held 60 cycles, long pulse 32 after press
    key_a = 1'b0;
    quiet("s3_wait", 0, 10, O_IDLE);
    step("s3_press", 0, O_PRESS);
    quiet("s3_hold", 0, 31, O_HELD);
    step("s3_long", 0, O_LONG);
    quiet("s3_held", 0, 17, O_HOLD);
    key_a = 1'b1;
    quiet("s3_rwait", 0, 10, O_HOLD);
    step("s3_rel", 0, O_REL);
    quiet("s3_idle", 0, 3, O_IDLE);

    // 4: 4-cycle release glitch at lcnt=20 delays the long pulse by 5
    key_a = 1'b0;
    quiet("s4_wait", 0, 10, O_IDLE);
    step("s4_press", 0, O_PRESS);
    quiet("s4_pre", 0, 9, O_HELD);
    key_a = 1'b1;
    quiet("s4_glitch", 0, 4, O_HELD);
    key_a = 1'b0;
    quiet("s4_resume", 0, 23, O_HELD);
    step("s4_long", 0, O_LONG);

    // 5: reset while in LONG_HELD, then a fresh press with key still down
    quiet("s5_held", 0, 3, O_HOLD);
    reset_n = 1'b0;
    #1;
    chk("s5_rst_now", outs_a, O_IDLE);
    quiet("s5_in_rst", 0, 2, O_IDLE);
    reset_n = 1'b1;
    quiet("s5_wait", 0, 10, O_IDLE);
    step("s5_press", 0, O_PRESS);
    key_a = 1'b1;
    quiet("s5_rwait", 0, 10, O_HELD);
    step("s5_rel", 0, O_REL);
    quiet("s5_idle", 0, 2, O_IDLE);

    // 6: active-high instance, same timing as scenario 1
    key_b = 1'b1;
    quiet("s6_wait", 1, 10, O_IDLE);
    step("s6_press", 1, O_PRESS);
    step("s6_hold", 1, O_HELD);
    key_b = 1'b0;
    quiet("s6_rwait", 1, 10, O_HELD);
    step("s6_rel", 1, O_REL);
    step("s6_idle", 1, O_IDLE);
    chk("s6_a_idle", outs_a, O_IDLE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
